// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the counter enable controller.
//   state_t   : FSM state encoding (IDLE / RUN / STEP)
//   cnt_width : width of a counter that must hold 0 .. n-1 (at least 1 bit)
package count_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10
   } state_t;

   function automatic int cnt_width(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter and a
// rising-edge detector on the debounced level.
//   Clk   : system clock, rising edge
//   Rst   : asynchronous active-low reset
//   Btn   : raw pushbutton, asynchronous to Clk, 1 = pressed
//   press : one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce
   import count_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Btn,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          db_level;
   logic          db_level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         db_level   <= 1'b0;
         db_level_d <= 1'b0;
         cnt        <= '0;
      end else begin
         s1         <= Btn;
         s2         <= s1;
         db_level_d <= db_level;
         // A sample equal to the accepted level clears the count, so any
         // bounce back restarts the stability window.
         if (s2 != db_level) begin
            if (cnt == CNT_LAST) begin
               db_level <= s2;
               cnt      <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press = db_level & ~db_level_d;

endmodule

// File: rtl/count_enable_ctrl.sv
// Enable generator for the 3-bit up counter. A debounced button press
// starts/stops free-run mode (periodic En every PRESCALE clocks) or, in
// single-step mode, produces exactly one En per press.
//   Clk     : system clock, rising edge
//   Rst     : asynchronous active-low reset
//   Btn     : raw pushbutton, 1 = pressed
//   Mode    : 1 = free-run, 0 = single-step (only looked at in IDLE)
//   Carry2  : counter carry-out (Count==7), used only for auto-stop
//   En      : count-enable strobe to the counter
//   Running : 1 while in RUN
// Build option: define AUTO_STOP_EN to leave RUN when an En coincides with
// Carry2, so the counter halts after wrapping 7 -> 0.
module count_enable_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PRESCALE        = 5
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Btn,
   input  logic Mode,
   input  logic Carry2,
   output logic En,
   output logic Running
);

   localparam int PW = cnt_width(PRESCALE);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_nxt;
   logic          press;
   logic          run_tick;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .Clk   (Clk),
      .Rst   (Rst),
      .Btn   (Btn),
      .press (press)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         presc <= '0;
      end else begin
         state <= state_nxt;
         presc <= presc_nxt;
      end
   end

   // Outputs decode registered state only, so reset clears them at once.
   assign run_tick = (state == RUN) && (presc == PRESC_LAST);
   assign En       = (state == STEP) || run_tick;
   assign Running  = (state == RUN);

`ifndef AUTO_STOP_EN
   logic unused_carry2;
   assign unused_carry2 = Carry2;
`endif

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      case (state)
         IDLE: begin
            presc_nxt = '0;
            if (press) state_nxt = Mode ? RUN : STEP;
         end
         RUN: begin
            presc_nxt = run_tick ? '0 : presc + PW'(1);
            // A press on an En cycle still lets that En out; it only
            // decides the next state.
            if (press) begin
               state_nxt = IDLE;
               presc_nxt = '0;
            end
`ifdef AUTO_STOP_EN
            if (run_tick && Carry2) begin
               state_nxt = IDLE;
               presc_nxt = '0;
            end
`endif
         end
         STEP: begin
            state_nxt = IDLE;
            presc_nxt = '0;
         end
         default: begin
            state_nxt = IDLE;
            presc_nxt = '0;
         end
      endcase
   end

endmodule

// File: doc/count_enable_ctrl.md
Name: count_enable_ctrl

Overview:
Upstream enable generator for the 3-bit up counter. Synchronises and debounces a raw pushbutton, then drives the counter's one-cycle En strobe. In free-run mode En is a periodic prescaled tick; in single-step mode each press gives exactly one En. Carry2 from the counter feeds back for the optional auto-stop.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a button level change (>=1)
PRESCALE, 5, En period in clocks while running (>=1; 1 = En every cycle)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-low reset (0 = reset)
Btn  input  1  raw pushbutton, asynchronous to Clk, 1 = pressed
Mode  input  1  1 = free-run, 0 = single-step; sampled only in IDLE
Carry2  input  1  counter carry-out (Count==7); used only with AUTO_STOP_EN
En  output  1  count-enable strobe to the up counter
Running  output  1  1 while in RUN state

Behaviour:
- Reset (Rst=0, async): sync flops, debounced level, debounce counter, prescaler and FSM go to 0/IDLE. En=0, Running=0 immediately, not on a clock edge.
- Sync: Btn passes through a 2-flop synchroniser (s1 -> s2).
- Debounce:
  - While s2 != db_level, cnt increments.
  - When s2 != db_level and cnt == DEBOUNCE_CYCLES-1: db_level <= s2 and cnt <= 0.
  - When s2 == db_level: cnt <= 0.
  - Any bounce restarts the count.
- press = db_level & ~db_level_d. It is a one-cycle pulse, first high 2+DEBOUNCE_CYCLES edges after the first edge that samples Btn=1. Release produces no press. A held button gives exactly one press.
- FSM states: IDLE, RUN, STEP (registered).
  - IDLE: press & Mode=1 -> RUN with presc <= 0. press & Mode=0 -> STEP. Otherwise stay.
  - RUN: presc increments and wraps PRESCALE-1 -> 0. press -> IDLE with presc <= 0. Mode changes are ignored.
  - STEP: unconditionally -> IDLE after one cycle.
- En = (state==STEP) | (state==RUN & presc==PRESCALE-1). It is decoded from registers only; no input reaches En combinationally.
  - First En in RUN is on the PRESCALE-th cycle after entry. Period is exactly PRESCALE.
  - STEP gives exactly one En per press.
- Running = (state==RUN).
- press in the same cycle as a RUN En: that En is still issued, the next state is IDLE, and no further En follows.
- Counter widths: ceil(log2) of each parameter, minimum 1 bit. Arithmetic is unsigned and wraps only as specified.

Optional Feature:
AUTO_STOP_EN
- Defined: in RUN, if En=1 and Carry2=1 in the same cycle, next state is IDLE and presc <= 0. The counter therefore stops after wrapping 7 -> 0. If press coincides with this, the result is still IDLE.
- Undefined: Carry2 is ignored, and RUN continues until a press.

Decomposition:
- Shared package/header count_ctrl_pkg: state encoding (IDLE=2'b00, RUN=2'b01, STEP=2'b10) and a clog2-style width helper.
- Sub-module btn_debounce (Clk, Rst, Btn -> press): contains the synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES.
- count_enable_ctrl holds the FSM, the prescaler and the output decode.

Test Plan:
1. Rst=0 for 2 cycles with Btn=0, then Rst=1 -> En=0, Running=0; no En for 50 cycles.
2. Btn=1 for 3 cycles then 0 (DEBOUNCE_CYCLES=4) -> no press, state stays IDLE, En never asserts.
3. Mode=1, Btn=1 for 10 cycles -> Running=1. En is high 1 cycle out of every 5, first En on the 5th RUN cycle. Second 10-cycle press -> Running=0 and no En afterwards.
4. Mode=0, Btn held 60 cycles -> exactly one En pulse; Running stays 0. A second press gives exactly one more En.
5. In RUN with presc=2, drive Rst=0 mid-cycle -> En=0 and Running=0 before the next edge. After release the block is idle and presc restarts at 0.
6. With AUTO_STOP_EN defined: RUN, Carry2=1 on an En cycle -> IDLE next cycle, no further En. Without the macro, same stimulus -> RUN continues with En every 5 cycles.
